// File: rtl/uart_pg_loader.sv
// UART program downloader: 8N1 receiver feeding a length-prefixed word loader.
// Optional trailing XOR checksum byte is enabled by defining PG_CHECKSUM_EN.
`timescale 1ns/1ps
module uart_pg_loader #(
    parameter int CLK_HZ = 10_000_000,
    parameter int BAUD   = 115200
) (
    input  logic        pg_clk_i,
    input  logic        pg_rst_i,
    input  logic        uart_rx,
    output logic        pg_wen,
    output logic [15:0] pg_din,
    output logic [15:0] pg_adr,
    output logic        pg_done,
    output logic        pg_err,
    output logic        cpu_hold
);

    localparam int          DIV    = CLK_HZ / BAUD;
    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
    localparam logic [15:0] HALF   = 16'(DIV / 2);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;

    typedef enum logic [2:0] {
        S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI,
`ifdef PG_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE, S_ERR
    } st_t;

`ifdef PG_CHECKSUM_EN
    localparam st_t S_FIN = S_CSUM;
`else
    localparam st_t S_FIN = S_DONE;
`endif

    logic        rx_s1_q, rx_s2_q, rx_s3_q;
    rx_t         rx_q, rx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        bv_q, bv_d;
    logic        frame_err;

    st_t         st_q, st_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] rem_q, rem_d;
    logic        wen_q, wen_d;
    logic [15:0] din_q, din_d;
    logic [15:0] adr_q, adr_d;
`ifdef PG_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    // rx_s3_q is the previous synchronized sample, used for edge detection
    always_ff @(posedge pg_clk_i) begin
        if (pg_rst_i) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
            rx_q    <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            bv_q    <= 1'b0;
        end else begin
            rx_s1_q <= uart_rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            bv_q    <= bv_d;
        end
    end

    always_comb begin
        rx_d      = rx_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        bv_d      = 1'b0;
        frame_err = 1'b0;
        unique case (rx_q)
            RX_IDLE: begin
                if (rx_s3_q && !rx_s2_q) begin
                    rx_d  = RX_START;
                    cnt_d = '0;
                end
            end
            RX_START: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    bit_d = '0;
                    rx_d  = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == DIV_M1) begin
                    cnt_d = '0;
                    sh_d  = {rx_s2_q, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_d = RX_STOP;
                end
            end
            RX_STOP: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == DIV_M1) begin
                    cnt_d     = '0;
                    rx_d      = RX_IDLE;
                    bv_d      = rx_s2_q;
                    frame_err = !rx_s2_q;
                end
            end
            default: rx_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge pg_clk_i) begin
        if (pg_rst_i) begin
            st_q   <= S_LEN_LO;
            lo_q   <= '0;
            rem_q  <= '0;
            wen_q  <= 1'b0;
            din_q  <= '0;
            adr_q  <= '0;
`ifdef PG_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            st_q   <= st_d;
            lo_q   <= lo_d;
            rem_q  <= rem_d;
            wen_q  <= wen_d;
            din_q  <= din_d;
            adr_q  <= adr_d;
`ifdef PG_CHECKSUM_EN
            csum_q <= csum_d;
`endif
        end
    end

    always_comb begin
        st_d   = st_q;
        lo_d   = lo_q;
        rem_d  = rem_q;
        wen_d  = 1'b0;
        din_d  = din_q;
        adr_d  = wen_q ? adr_q + 16'd1 : adr_q;
`ifdef PG_CHECKSUM_EN
        csum_d = csum_q;
        if (bv_q) csum_d = csum_q ^ sh_q;
`endif
        if (frame_err && st_q != S_DONE && st_q != S_ERR) begin
            st_d = S_ERR;
        end else if (bv_q) begin
            unique case (st_q)
                S_LEN_LO: begin
                    lo_d = sh_q;
                    st_d = S_LEN_HI;
                end
                S_LEN_HI: begin
                    rem_d = {sh_q, lo_q};
                    st_d  = ({sh_q, lo_q} == 16'd0) ? S_FIN : S_DATA_LO;
                end
                S_DATA_LO: begin
                    lo_d = sh_q;
                    st_d = S_DATA_HI;
                end
                S_DATA_HI: begin
                    wen_d = 1'b1;
                    din_d = {sh_q, lo_q};
                    rem_d = rem_q - 16'd1;
                    st_d  = (rem_q == 16'd1) ? S_FIN : S_DATA_LO;
                end
`ifdef PG_CHECKSUM_EN
                S_CSUM: st_d = (sh_q == csum_q) ? S_DONE : S_ERR;
`endif
                default: st_d = st_q;
            endcase
        end
    end

    assign pg_wen   = wen_q;
    assign pg_din   = din_q;
    assign pg_adr   = adr_q;
    assign pg_done  = (st_q == S_DONE);
    assign pg_err   = (st_q == S_ERR);
    assign cpu_hold = (st_q != S_DONE);

endmodule

// File: tb/tb_uart_pg_loader.sv
// Bench for uart_pg_loader: directed and random frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_pg_loader;

    localparam int DIV = 10_000_000 / 115200;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        pg_wen;
    logic [15:0] pg_din;
    logic [15:0] pg_adr;
    logic        pg_done;
    logic        pg_err;
    logic        cpu_hold;

    int n_run  = 0;
    int n_fail = 0;

    longint      cyc = 0;
    longint      last_wen_cyc = -1;
    longint      done_cyc = -1;
    logic [31:0] wq[$];
    int          wide = 0;
    logic        wen_prev = 1'b0;
    logic        done_prev = 1'b0;

    uart_pg_loader dut (
        .pg_clk_i (clk),
        .pg_rst_i (rst),
        .uart_rx  (rx),
        .pg_wen   (pg_wen),
        .pg_din   (pg_din),
        .pg_adr   (pg_adr),
        .pg_done  (pg_done),
        .pg_err   (pg_err),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (pg_wen) begin
            wq.push_back({pg_adr, pg_din});
            last_wen_cyc = cyc;
            if (wen_prev) wide++;
        end
        if (pg_done && !done_prev) done_cyc = cyc;
        wen_prev  = pg_wen;
        done_prev = pg_done;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic glitch();
        rx = 1'b0;
        repeat (DIV * 3 / 10) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
    endtask

    // Model: words whose high byte lands before the first bad byte are
    // written; a bad byte inside the frame or a wrong checksum is an error.
    task automatic run_frame(input string nm, input bq_t pl, input bit corrupt,
                             input int bad, input bq_t extra);
        bq_t         s;
        int          n, flen, good, nw, nobs;
        bit          err;
        logic [7:0]  x;
        wq.delete();
        wide = 0;
        done_cyc = -1;
        last_wen_cyc = -1;
        s = pl;
        n = {pl[1], pl[0]};
        flen = 2 + 2 * n;
        err = 1'b0;
`ifdef PG_CHECKSUM_EN
        x = 8'h00;
        foreach (pl[i]) x ^= pl[i];
        s.push_back(corrupt ? (x ^ 8'h5A) : x);
        flen++;
        if (corrupt) err = 1'b1;
`else
        x = 8'h00;
`endif
        foreach (extra[i]) s.push_back(extra[i]);
        foreach (s[i]) send_byte(s[i], i != bad);
        repeat (8) @(negedge clk);
        good = (bad >= 0 && bad < flen) ? bad : flen;
        if (bad >= 0 && bad < flen) err = 1'b1;
        nw = (good >= 2) ? (good - 2) / 2 : 0;
        if (nw > n) nw = n;
        nobs = wq.size();
        chk({nm, ".nwr"}, nobs, nw);
        for (int j = 0; j < nobs && j < nw; j++)
            chk({nm, ".wr"}, wq[j], {16'(j), pl[3 + 2 * j], pl[2 + 2 * j]});
        chk({nm, ".done"}, pg_done, !err);
        chk({nm, ".err"}, pg_err, err);
        chk({nm, ".hold"}, cpu_hold, err);
        chk({nm, ".wide"}, wide, 0);
`ifndef PG_CHECKSUM_EN
        if (!err && n > 0)
            chk({nm, ".donecyc"}, 32'(done_cyc - last_wen_cyc), 0);
`endif
    endtask

    initial begin
        bq_t p, e, none;
        int  n, flen, bad;
        none = {};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.wen",  pg_wen,   0);
        chk("rst.din",  pg_din,   0);
        chk("rst.adr",  pg_adr,   0);
        chk("rst.done", pg_done,  0);
        chk("rst.err",  pg_err,   0);
        chk("rst.hold", cpu_hold, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        p = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB};
        run_frame("two", p, 1'b0, -1, none);

        do_reset();
        p = '{8'h00, 8'h00};
        e = '{8'h55, 8'hAA};
        run_frame("zero", p, 1'b0, -1, e);

        do_reset();
        glitch();
        p = '{8'h01, 8'h00, 8'hEF, 8'hBE};
        run_frame("glitch", p, 1'b0, -1, none);

        do_reset();
        p = '{8'h01, 8'h00, 8'h34, 8'h12};
        run_frame("ferr", p, 1'b0, 1, none);

        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hEF, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid.wen",  pg_wen,   0);
        chk("mid.din",  pg_din,   0);
        chk("mid.adr",  pg_adr,   0);
        chk("mid.done", pg_done,  0);
        chk("mid.err",  pg_err,   0);
        chk("mid.hold", cpu_hold, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        p = '{8'h01, 8'h00, 8'h11, 8'h22};
        run_frame("after", p, 1'b0, -1, none);

`ifdef PG_CHECKSUM_EN
        do_reset();
        p = '{8'h01, 8'h00, 8'h34, 8'h12};
        run_frame("badsum", p, 1'b1, -1, none);
`endif

        for (int k = 0; k < 5; k++) begin
            n = $urandom_range(1, 3);
            p = '{8'(n), 8'h00};
            for (int j = 0; j < 2 * n; j++) p.push_back(8'($urandom));
            flen = 2 + 2 * n;
`ifdef PG_CHECKSUM_EN
            flen++;
`endif
            bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, flen) : -1;
            e = '{8'($urandom)};
            do_reset();
            run_frame("rnd", p, $urandom_range(0, 2) == 0, bad, e);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
